interrupt_source_conditioner: RTL
=================================

// Module: interrupt_source_conditioner
// PURPOSE
//  Front end for Interrupt_Register: 2-flop synchronises, debounces and rising-edge detects raw switches.
//  Detected edges accumulate in a pending mask. One-cycle Write strobes hand the mask to Interrupt_Register.
//  Interrupt_Register latches on Write, so the conditioner is the only agent allowed to drive Write.
// PARAMETERS
//  NUM_SRC       4   number of interrupt sources (Sw0..Sw3 of Interrupt_Register)
//  DEBOUNCE_CYC  16  consecutive stable synced cycles before the debounced level changes (>=2)
//  CNT_W         5   debounce counter width, must hold DEBOUNCE_CYC
// PORTS
//  CLK      in   1        system clock, all state on rising edge
//  CLR      in   1        asynchronous active-high reset
//  Raw_Sw   in   NUM_SRC  raw asynchronous switch/button levels
//  Hold     in   1        1 = downstream busy; suppress Write, keep accumulating
//  Write    out  1        one-cycle strobe to Interrupt_Register
//  Sw_Out   out  NUM_SRC  request mask valid only while Write=1, else 0
//  Pending  out  NUM_SRC  current un-forwarded edge mask (status/debug)
// BEHAVIOUR
//  Reset (CLR=1, async): sync flops, debounced levels, counters, Pending, Write and Sw_Out all go to 0.
//    Overrun also goes to 0. A switch held high through reset produces no edge until it falls and rises again.
//  Sync: 2 flops per bit. Debounce is evaluated on the 2nd flop (synced level s).
//  Debounce per bit:
//    s==deb -> counter=0.
//    s!=deb -> counter++. When counter==DEBOUNCE_CYC-1: deb<=s and counter<=0.
//    Any glitch back to deb restarts the count.
//  Edge: rise = deb_next & ~deb (one cycle). Falling edges are ignored.
//  Latency: a clean 0->1 on Raw_Sw sets Pending 2+DEBOUNCE_CYC cycles later. Write rises the following cycle when Hold=0.
//  Forwarding FSM, 2 states:
//    IDLE: if Pending!=0 && !Hold -> ISSUE.
//    ISSUE: Write=1, Sw_Out=Pending snapshot; cleared bits = snapshot; -> IDLE.
//    Write is therefore never high two cycles in a row. Minimum spacing is 1 idle cycle.
//  Hold sampled in IDLE only. Hold rising during ISSUE does not cancel the strobe in flight.
//  Simultaneous: a rise on bit k in the ISSUE cycle:
//    bit k in snapshot -> bit k stays set in Pending (new event, not lost).
//    bit k not in snapshot -> bit k is simply set.
//    Pending_next = (Pending & ~snapshot) | rise.
//  Repeat edge on an already-pending bit merges (no count). See the optional overrun flag below.
//  CLR mid-ISSUE: Write drops asynchronously; the request is discarded.
// CONFIGURATION
//  SRC_OVERRUN_EN defined:
//    Adds output Overrun (NUM_SRC, sticky). Bit k sets when rise[k] arrives while Pending[k]==1 and bit k is not being forwarded.
//    Cleared only by CLR.
//  Undefined: no Overrun port; merges are silent.
// STRUCTURE
//  Shared package interrupt_pkg:
//    NUM_SRC constant.
//    state enum {IDLE, ISSUE}.
//    clog2-based CNT_W helper, also used by Interrupt_Register.
//  Sub-module src_debounce: sync+counter+edge for one bit, generate-instantiated NUM_SRC times.
//  Top holds the Pending register and the FSM.
// TESTING
//  T1 reset: CLR=1 with Raw_Sw=4'hF -> Write=0, Sw_Out=0, Pending=0. Release CLR -> no Write ever.
//  T2 clean press:
//    Raw_Sw[2] 0->1 -> Pending=4'b0100 at cycle 18.
//    Next cycle: Write=1 with Sw_Out=4'b0100, then Pending=0.
//  T3 bounce: toggle Raw_Sw[0] every 5 cycles for 60 cycles, then hold 1 -> exactly one Write, Sw_Out=4'b0001.
//  T4 Hold:
//    Hold=1; press bits 1 and 3 twenty cycles apart -> Pending=4'b1010, no Write.
//    Drop Hold -> single Write, Sw_Out=4'b1010.
//  T5 collision: time a bit-0 rise to land in the ISSUE cycle of a bit-0 Write.
//    -> Pending[0]=1 afterwards; a second Write with Sw_Out=4'b0001 two cycles later.
//  T6 (SRC_OVERRUN_EN): Hold=1, press/release/press bit 1 -> Overrun=4'b0010 stays set until CLR.

Source files
------------

// File: rtl/interrupt_pkg.sv
// Shared constants and types for the interrupt front end and Interrupt_Register.
// cnt_width() sizes a counter that must be able to hold a given cycle count.
package interrupt_pkg;

    localparam int NUM_SRC      = 4;
    localparam int DEBOUNCE_CYC = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    function automatic int cnt_width(input int cyc);
        return (cyc < 2) ? 1 : $clog2(cyc + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEBOUNCE_CYC);

endpackage

// File: rtl/src_debounce.sv
// One interrupt source: 2-flop synchroniser, stable-count debouncer and rising-edge pulse.
// rise_o is combinational and lasts exactly the cycle in which the debounced level goes high.
module src_debounce
    import interrupt_pkg::*;
#(
    parameter int DEB_CYC = DEBOUNCE_CYC,
    parameter int CW      = CNT_W
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic raw_i,
    output logic rise_o
);

    logic [1:0]    sync_q;
    logic [1:0]    vld_q;
    logic          deb_q, deb_d;
    logic          arm_q, arm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s;

    assign s = sync_q[1];

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (s != deb_q) begin
            if (cnt_q == CW'(DEB_CYC - 1)) begin
                deb_d = s;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Edges are only reported once the synced input has been seen low, so a
    // switch held high through reset must fall and rise again to count.
    assign arm_d  = arm_q | (vld_q[1] & ~s & ~deb_q);
    assign rise_o = deb_d & ~deb_q & arm_q;

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            sync_q <= '0;
            vld_q  <= '0;
            deb_q  <= 1'b0;
            arm_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            vld_q  <= {vld_q[0], 1'b1};
            deb_q  <= deb_d;
            arm_q  <= arm_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/interrupt_source_conditioner.sv
// Conditions raw switches into a pending mask and forwards it to Interrupt_Register as one-cycle Write strobes.
// Define SRC_OVERRUN_EN to add the sticky Overrun output flagging edges merged into an already-pending bit.
module interrupt_source_conditioner
    import interrupt_pkg::*;
(
    input  logic               CLK,
    input  logic               CLR,
    input  logic [NUM_SRC-1:0] Raw_Sw,
    input  logic               Hold,
    output logic               Write,
    output logic [NUM_SRC-1:0] Sw_Out,
    output logic [NUM_SRC-1:0] Pending
`ifdef SRC_OVERRUN_EN
    ,
    output logic [NUM_SRC-1:0] Overrun
`endif
);

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] snap_q, snap_d;
    logic [NUM_SRC-1:0] fwd;
    logic [NUM_SRC-1:0] rise;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        src_debounce #(
            .DEB_CYC (DEBOUNCE_CYC),
            .CW      (CNT_W)
        ) u_deb (
            .clk_i  (CLK),
            .clr_i  (CLR),
            .raw_i  (Raw_Sw[k]),
            .rise_o (rise[k])
        );
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        fwd     = '0;
        case (state_q)
            IDLE: begin
                if ((pend_q != '0) && !Hold) begin
                    state_d = ISSUE;
                    snap_d  = pend_q;
                end
            end
            ISSUE: begin
                fwd     = snap_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A rise landing in the ISSUE cycle re-sets its bit after the snapshot clears it.
    assign pend_d = (pend_q & ~fwd) | rise;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= IDLE;
            snap_q  <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            pend_q  <= pend_d;
        end
    end

    assign Write   = (state_q == ISSUE);
    assign Sw_Out  = Write ? snap_q : '0;
    assign Pending = pend_q;

`ifdef SRC_OVERRUN_EN
    logic [NUM_SRC-1:0] ovr_q, ovr_d;

    assign ovr_d = ovr_q | (rise & pend_q & ~fwd);

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign Overrun = ovr_q;
`endif

endmodule
